// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
package ifq_pkg;

  localparam int          DEFAULT_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR     = 32'h00000013;

  // One queued fetch result at the default PC width.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] pc;
    logic [31:0]              instr;
  } ifq_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-side and decode-side valid/ready handshake bundle for the fetch queue.
interface instr_fetch_queue_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_pc;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pc;
  logic [31:0]      out_instr;

  // The queue itself.
  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );

  // Whoever drives fetch results in and consumes them at decode.
  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/instr_fetch_queue_ptr.sv
// Queue pointer with wrap bit: increments on inc, clears synchronously on clr
// (clr wins over inc). The MSB toggles each time the index wraps.
module ifq_ptr #(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_d;
  logic [PW-1:0] ptr_q;

  // Next pointer value: clear, advance or hold.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + PW'(1);
    end
  end

  // Pointer register, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry FIFO of {pc, instr} between fetch and
// decode, with valid/ready on both sides and a synchronous flush for taken
// branches. Build option IFQ_BYPASS_EN adds a zero-latency pass-through when
// the queue is empty and decode is ready; without it there is no
// combinational path from in_* to out_*.
// DEPTH must be a power of two and at least 2.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  instr_fetch_queue_if.slave       bus,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            PW      = AW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [31:0]      instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] occ;
  logic          full;
  logic          empty;
  logic          bypass;
  logic          push;
  logic          pop;
  entry_t        head;

  ifq_ptr #(.PW(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst),
    .clr   (flush),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  ifq_ptr #(.PW(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst),
    .clr   (flush),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  // Occupancy, handshakes and the head-of-queue selection.
  always_comb begin
    occ   = wr_ptr - rd_ptr;
    full  = (occ == DEPTH_C);
    empty = (occ == '0);

`ifdef IFQ_BYPASS_EN
    bypass = empty && !flush && bus.in_valid && bus.out_ready;
`else
    bypass = 1'b0;
`endif

    bus.in_ready = !full && !flush;
    // A bypassed instruction goes straight to decode and is never stored.
    push = bus.in_valid && bus.in_ready && !bypass;
    // Flush has priority: a pop in the flush cycle is discarded with the rest.
    pop  = !empty && bus.out_ready && !flush;

    head.pc    = '0;
    head.instr = NOP_INSTR;
    if (!empty) begin
      head = mem_q[rd_ptr[AW-1:0]];
    end else if (bypass) begin
      head.pc    = bus.in_pc;
      head.instr = bus.in_instr;
    end

    bus.out_valid = !empty || bypass;
    bus.out_pc    = head.pc;
    bus.out_instr = head.instr;
    count         = occ;
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr[AW-1:0]] <= '{pc: bus.in_pc, instr: bus.in_instr};
    end
  end

endmodule
